icache_refill_unit: RTL and testbench

//  Memory-side responder for the Icache miss/refill interface. Accepts line-miss requests,

---
 rtl/icache_pkg.sv | 17 +
 rtl/icache_refill_unit_if.sv | 38 +++
 rtl/icache_miss_fifo.sv | 40 ++++
 rtl/icache_refill_unit.sv | 107 ++++++++++
 tb/tb_icache_refill_unit.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/icache_pkg.sv
// Shared constants and FSM state encoding for the Icache refill path.
package icache_pkg;

    localparam int LINE_SIZE      = 512;
    localparam int OFFSET_WIDTH   = 6;
    localparam int MEM_DATA_WIDTH = 64;
    localparam int BEAT_NUM       = LINE_SIZE / MEM_DATA_WIDTH;
    localparam int BEAT_CNT_WIDTH = $clog2(BEAT_NUM);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        BEAT = 2'd2,
        RESP = 2'd3
    } refill_state_e;

endpackage

// File: rtl/icache_refill_unit_if.sv
// Miss, refill, memory and perf signals of the refill unit; slave = unit side, master = environment side.
// Handshakes: a transfer happens on a rising clk edge where valid and ready are both high; a raised valid
// and its payload stay stable until that edge. mem_resp_valid_i has no ready and is taken unconditionally.
interface icache_refill_unit_if #(
    parameter int ADDR_WIDTH = 64
);
    import icache_pkg::*;

    logic                      icache_miss_valid_i;
    logic                      icache_miss_ready_o;
    logic [ADDR_WIDTH-1:0]     icache_miss_addr_i;
    logic                      refill_icache_valid_o;
    logic                      refill_icache_ready_i;
    logic [LINE_SIZE-1:0]      refill_icache_data_o;
    logic                      mem_req_valid_o;
    logic                      mem_req_ready_i;
    logic [ADDR_WIDTH-1:0]     mem_req_addr_o;
    logic                      mem_resp_valid_i;
    logic [MEM_DATA_WIDTH-1:0] mem_resp_data_i;
    logic [31:0]               perf_miss_cnt_o;
    logic [31:0]               perf_busy_cycles_o;
    refill_state_e             dbg_state;

    modport slave (
        input  icache_miss_valid_i, icache_miss_addr_i, refill_icache_ready_i,
               mem_req_ready_i, mem_resp_valid_i, mem_resp_data_i,
        output icache_miss_ready_o, refill_icache_valid_o, refill_icache_data_o,
               mem_req_valid_o, mem_req_addr_o, perf_miss_cnt_o, perf_busy_cycles_o, dbg_state
    );

    modport master (
        output icache_miss_valid_i, icache_miss_addr_i, refill_icache_ready_i,
               mem_req_ready_i, mem_resp_valid_i, mem_resp_data_i,
        input  icache_miss_ready_o, refill_icache_valid_o, refill_icache_data_o,
               mem_req_valid_o, mem_req_addr_o, perf_miss_cnt_o, perf_busy_cycles_o, dbg_state
    );

endinterface

// File: rtl/icache_miss_fifo.sv
// In-order miss queue holding line tags; pointers carry an extra wrap bit to tell full from empty.
module icache_miss_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 58
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);

    logic [PW:0]      wr_ptr;
    logic [PW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push && !full) begin
                mem[wr_ptr[PW-1:0]] <= din;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign dout  = mem[rd_ptr[PW-1:0]];

endmodule

// File: rtl/icache_refill_unit.sv
// Queues Icache line misses and fetches each line from memory as a burst of beats, one burst at a time.
// Optional perf counters are built only when ICACHE_REFILL_PERF_EN is defined.
module icache_refill_unit
    import icache_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int REQ_DEPTH  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    icache_refill_unit_if.slave  bus
);

    localparam int TAG_WIDTH = ADDR_WIDTH - OFFSET_WIDTH;

    refill_state_e               state_q;
    refill_state_e               state_d;
    logic [BEAT_CNT_WIDTH-1:0]   beat_cnt_q;
    logic [LINE_SIZE-1:0]        line_q;
    logic [TAG_WIDTH-1:0]        head_tag;
    logic                        q_full;
    logic                        q_empty;
    logic                        push;
    logic                        pop;
    logic                        last_beat;

    assign push      = bus.icache_miss_valid_i && !q_full;
    assign pop       = (state_q == REQ) && bus.mem_req_ready_i;
    assign last_beat = bus.mem_resp_valid_i && (beat_cnt_q == BEAT_CNT_WIDTH'(BEAT_NUM - 1));

    icache_miss_fifo #(
        .DEPTH (REQ_DEPTH),
        .WIDTH (TAG_WIDTH)
    ) u_miss_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (bus.icache_miss_addr_i[ADDR_WIDTH-1:OFFSET_WIDTH]),
        .pop   (pop),
        .dout  (head_tag),
        .full  (q_full),
        .empty (q_empty)
    );

    // A miss accepted this cycle counts as pending so the request goes out on the next cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (push || !q_empty) state_d = REQ;
            REQ:  if (bus.mem_req_ready_i) state_d = BEAT;
            BEAT: if (last_beat) state_d = RESP;
            RESP: if (bus.refill_icache_ready_i) state_d = (push || !q_empty) ? REQ : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            beat_cnt_q <= '0;
            line_q     <= '0;
        end else begin
            state_q <= state_d;
            if (pop) beat_cnt_q <= '0;
            if ((state_q == BEAT) && bus.mem_resp_valid_i) begin
                line_q[int'(beat_cnt_q)*MEM_DATA_WIDTH +: MEM_DATA_WIDTH] <= bus.mem_resp_data_i;
                beat_cnt_q <= beat_cnt_q + 1'b1;
            end
        end
    end

    assign bus.icache_miss_ready_o   = !q_full;
    assign bus.mem_req_valid_o       = (state_q == REQ);
    assign bus.mem_req_addr_o        = {head_tag, {OFFSET_WIDTH{1'b0}}};
    assign bus.refill_icache_valid_o = (state_q == RESP);
    assign bus.refill_icache_data_o  = line_q;
    assign bus.dbg_state             = state_q;

`ifdef ICACHE_REFILL_PERF_EN
    logic [31:0] perf_miss_q;
    logic [31:0] perf_busy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_miss_q <= '0;
            perf_busy_q <= '0;
        end else begin
            if (push) perf_miss_q <= perf_miss_q + 1'b1;
            if (state_q != IDLE) perf_busy_q <= perf_busy_q + 1'b1;
        end
    end

    assign bus.perf_miss_cnt_o    = perf_miss_q;
    assign bus.perf_busy_cycles_o = perf_busy_q;
`else
    assign bus.perf_miss_cnt_o    = 32'd0;
    assign bus.perf_busy_cycles_o = 32'd0;
`endif

`ifndef SYNTHESIS
    // Beats arriving with no burst in flight are dropped; flag them so the memory model can be fixed.
    stray_beat_a: assert property (@(posedge clk) disable iff (!rst_n)
        bus.mem_resp_valid_i |-> (state_q == BEAT))
        else $warning("stray memory response beat ignored");
`endif

endmodule

// File: tb/tb_icache_refill_unit.sv
// Directed bench for icache_refill_unit: table-driven single misses plus multi-cycle corner sequences.
module tb_icache_refill_unit;
  import icache_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  icache_refill_unit_if #(.ADDR_WIDTH(64)) bus ();

  icache_refill_unit #(.ADDR_WIDTH(64), .REQ_DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_cmp = 0;
  int n_err = 0;
  int n_refill = 0;
  logic [63:0] exp_q[$];

  typedef struct {
    logic [63:0] addr;
    logic [63:0] seed;
    logic [63:0] exp_addr;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.icache_miss_valid_i   = 1'b0;
    bus.icache_miss_addr_i    = '0;
    bus.refill_icache_ready_i = 1'b0;
    bus.mem_req_ready_i       = 1'b0;
    bus.mem_resp_valid_i      = 1'b0;
    bus.mem_resp_data_i       = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
  endtask

  function automatic logic [511:0] make_line(input logic [63:0] seed);
    logic [511:0] l;
    l = '0;
    for (int k = 0; k < 8; k++) l[k*64 +: 64] = seed + 64'(k);
    return l;
  endfunction

  task automatic miss(input string tag, input logic [63:0] addr);
    bus.icache_miss_valid_i = 1'b1;
    bus.icache_miss_addr_i  = addr;
    chk({tag, " miss_ready"}, bus.icache_miss_ready_o, 1'b1);
    step();
    bus.icache_miss_valid_i = 1'b0;
  endtask

  // Accepts the head request, plays 8 beats seed+k, checks the refill; acks it when ack_now is set.
  task automatic serve(input string tag, input logic [63:0] exp_addr, input logic [63:0] seed,
                       input bit ack_now);
    int w;
    w = 0;
    while (!bus.mem_req_valid_o && w < 40) begin
      step();
      w++;
    end
    chk({tag, " mem_req_valid"}, bus.mem_req_valid_o, 1'b1);
    chk({tag, " mem_req_addr"}, bus.mem_req_addr_o, exp_addr);
    bus.mem_req_ready_i = 1'b1;
    step();
    bus.mem_req_ready_i = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk({tag, " refill_valid_early"}, bus.refill_icache_valid_o, 1'b0);
      bus.mem_resp_valid_i = 1'b1;
      bus.mem_resp_data_i  = seed + 64'(k);
      step();
    end
    bus.mem_resp_valid_i = 1'b0;
    bus.mem_resp_data_i  = '0;
    chk({tag, " refill_valid"}, bus.refill_icache_valid_o, 1'b1);
    chk({tag, " refill_data"}, bus.refill_icache_data_o, make_line(seed));
    if (bus.refill_icache_valid_o) n_refill++;
    if (ack_now) begin
      bus.refill_icache_ready_i = 1'b1;
      step();
      bus.refill_icache_ready_i = 1'b0;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] a;
    logic [63:0] e;
    bit          bad;
    logic [31:0] exp_miss;
    logic [31:0] exp_busy;

    vecs[0] = '{64'h0000_0000_0000_1234, 64'h0,                   64'h0000_0000_0000_1200};
    vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hA5A5_0000_0000_0010, 64'hFFFF_FFFF_FFFF_FFC0};
    vecs[2] = '{64'h8000_0000_0000_0040, 64'h1111_2222_3333_4440, 64'h8000_0000_0000_0040};
    vecs[3] = '{64'h0000_0000_0000_003F, 64'hDEAD_BEEF_0000_0000, 64'h0};

    // reset state
    do_reset();
    chk("rst miss_ready", bus.icache_miss_ready_o, 1'b1);
    chk("rst mem_req_valid", bus.mem_req_valid_o, 1'b0);
    chk("rst mem_req_addr", bus.mem_req_addr_o, 64'h0);
    chk("rst refill_valid", bus.refill_icache_valid_o, 1'b0);
    chk("rst refill_data", bus.refill_icache_data_o, 512'h0);
    chk("rst state", bus.dbg_state, IDLE);
    chk("rst perf_miss", bus.perf_miss_cnt_o, 32'd0);
    chk("rst perf_busy", bus.perf_busy_cycles_o, 32'd0);

    // single misses from the vector table
    for (int i = 0; i < 4; i++) begin
      miss($sformatf("vec%0d", i), vecs[i].addr);
      chk($sformatf("vec%0d req_latency", i), bus.mem_req_valid_o, 1'b1);
      serve($sformatf("vec%0d", i), vecs[i].exp_addr, vecs[i].seed, 1'b1);
      chk($sformatf("vec%0d end_state", i), bus.dbg_state, IDLE);
      chk($sformatf("vec%0d end_refill_valid", i), bus.refill_icache_valid_o, 1'b0);
    end

    // queue fill with memory stalled: 4 accepted, 5th refused
    do_reset();
    n_refill = 0;
    for (int i = 0; i < 5; i++) begin
      a = 64'h0001_0000 + 64'(i) * 64'h40 + 64'(i);
      bus.icache_miss_valid_i = 1'b1;
      bus.icache_miss_addr_i  = a;
      if (i < 4) begin
        chk($sformatf("fill%0d ready", i), bus.icache_miss_ready_o, 1'b1);
        exp_q.push_back(a & ~64'h3F);
      end else begin
        chk("fill4 ready_low", bus.icache_miss_ready_o, 1'b0);
      end
      step();
    end
    bus.icache_miss_valid_i = 1'b0;
    chk("fill still_full", bus.icache_miss_ready_o, 1'b0);
    for (int j = 0; j < 4; j++) begin
      e = exp_q.pop_front();
      serve($sformatf("drain%0d", j), e, 64'h100 * 64'(j + 1), 1'b1);
    end
    chk("drain ready_back", bus.icache_miss_ready_o, 1'b1);
    a = 64'h0001_0000 + 64'h100 + 64'd4;
    miss("resend", a);
    serve("resend", a & ~64'h3F, 64'h0BAD_0000_0000_0500, 1'b1);
    chk("fill refill_count", 32'(n_refill), 32'd5);

    // refill held in RESP with a second miss pending
    do_reset();
    miss("hold0", 64'h2000_0008);
    miss("hold1", 64'h3000_0077);
    serve("hold0", 64'h2000_0000, 64'h7700_0000_0000_0000, 1'b0);
    for (int c = 0; c < 10; c++) begin
      step();
      chk($sformatf("hold c%0d refill_valid", c), bus.refill_icache_valid_o, 1'b1);
      chk($sformatf("hold c%0d refill_data", c), bus.refill_icache_data_o,
          make_line(64'h7700_0000_0000_0000));
      chk($sformatf("hold c%0d no_mem_req", c), bus.mem_req_valid_o, 1'b0);
    end
    bus.refill_icache_ready_i = 1'b1;
    step();
    bus.refill_icache_ready_i = 1'b0;
    chk("hold next_state", bus.dbg_state, REQ);
    serve("hold1", 64'h3000_0040, 64'h8800_0000_0000_0000, 1'b1);

    // enqueue on the same cycle as the refill handshake
    do_reset();
    miss("same0", 64'h4000_0010);
    serve("same0", 64'h4000_0000, 64'h0000_0000_0000_0020, 1'b0);
    bus.refill_icache_ready_i = 1'b1;
    bus.icache_miss_valid_i   = 1'b1;
    bus.icache_miss_addr_i    = 64'h5000_00C5;
    chk("same miss_ready", bus.icache_miss_ready_o, 1'b1);
    step();
    bus.refill_icache_ready_i = 1'b0;
    bus.icache_miss_valid_i   = 1'b0;
    chk("same state", bus.dbg_state, REQ);
    chk("same mem_req_valid", bus.mem_req_valid_o, 1'b1);
    chk("same mem_req_addr", bus.mem_req_addr_o, 64'h5000_00C0);
    serve("same1", 64'h5000_00C0, 64'h0000_0000_0000_0030, 1'b1);

    // reset in the middle of a burst, then stray beats
    do_reset();
    miss("mid", 64'h6000_0000);
    bus.mem_req_ready_i = 1'b1;
    step();
    bus.mem_req_ready_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus.mem_resp_valid_i = 1'b1;
      bus.mem_resp_data_i  = 64'hCAFE_0000_0000_0000 + 64'(k);
      step();
    end
    bus.mem_resp_valid_i = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst miss_ready", bus.icache_miss_ready_o, 1'b1);
    chk("midrst mem_req_valid", bus.mem_req_valid_o, 1'b0);
    chk("midrst mem_req_addr", bus.mem_req_addr_o, 64'h0);
    chk("midrst refill_valid", bus.refill_icache_valid_o, 1'b0);
    chk("midrst refill_data", bus.refill_icache_data_o, 512'h0);
    chk("midrst state", bus.dbg_state, IDLE);
    step();
    rst_n = 1'b1;
    bad = 1'b0;
    for (int c = 0; c < 12; c++) begin
      bus.mem_resp_valid_i = (c < 4);
      bus.mem_resp_data_i  = 64'hBEEF_0000_0000_0000 + 64'(c);
      step();
      if (bus.refill_icache_valid_o || bus.dbg_state != IDLE || bus.mem_req_valid_o) bad = 1'b1;
    end
    bus.mem_resp_valid_i = 1'b0;
    chk("midrst no_refill", bad, 1'b0);
    chk("midrst data_clear", bus.refill_icache_data_o, 512'h0);

    // perf counters over three isolated misses
    do_reset();
    for (int i = 0; i < 3; i++) begin
      a = 64'h7000_0000 + 64'(i) * 64'h1000;
      miss($sformatf("perf%0d", i), a);
      serve($sformatf("perf%0d", i), a, 64'h10 * 64'(i), 1'b1);
    end
    repeat (3) step();
`ifdef ICACHE_REFILL_PERF_EN
    exp_miss = 32'd3;
    exp_busy = 32'd30;
`else
    exp_miss = 32'd0;
    exp_busy = 32'd0;
`endif
    chk("perf miss_cnt", bus.perf_miss_cnt_o, exp_miss);
    chk("perf busy_cycles", bus.perf_busy_cycles_o, exp_busy);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
